// File: rtl/exception_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exception_entry_ctrl
// Description : Sequences exception entry for the core. It picks the
//               highest-priority request, reads PC and CPSR, then writes the
//               new CPSR, SPSR, LR and the vector PC.
// Revision    : 1.0 - initial release
// ============================================================================
module exception_entry_ctrl #(
    parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  exc_req,
    output logic [6:0]  exc_ack,
    output logic        busy,
    output logic        done,
    output logic        rf_read_en,
    output logic [3:0]  rf_read_reg,
    input  logic [31:0] rf_read_value,
    output logic        rf_write_en,
    output logic [3:0]  rf_write_reg,
    output logic [31:0] rf_write_value,
    output logic        cpsr_read_en,
    input  logic [31:0] cpsr_read_value,
    output logic        cpsr_write_en,
    output logic [31:0] cpsr_write_value,
    output logic        spsr_write_en,
    output logic [31:0] spsr_write_value
);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_RD_PC   = 3'd1;
    localparam logic [2:0] c_S_RD_CPSR = 3'd2;
    localparam logic [2:0] c_S_WR_CPSR = 3'd3;
    localparam logic [2:0] c_S_WR_SPSR = 3'd4;
    localparam logic [2:0] c_S_WR_LR   = 3'd5;
    localparam logic [2:0] c_S_WR_PC   = 3'd6;
    localparam logic [2:0] c_S_DONE    = 3'd7;

    // Bit positions of each source in exc_req / exc_ack
    localparam int c_RST = 0;
    localparam int c_UND = 1;
    localparam int c_SWI = 2;
    localparam int c_PAB = 3;
    localparam int c_DAB = 4;
    localparam int c_IRQ = 5;
    localparam int c_FIQ = 6;

    logic [2:0]  r_state;
    logic [6:0]  r_sel;
    logic [31:0] r_pc_cap;
    logic [31:0] r_cpsr_old;

    logic [6:0]  w_pick;
    logic [4:0]  w_mode;
    logic [7:0]  w_vec_off;
    logic        w_masked;
    logic [31:0] w_cpsr_new;
    logic [31:0] w_lr_value;
    logic [31:0] w_pc_value;

    // Fixed-priority selection: reset > dabort > fiq > irq > pabort > undef > swi
    always_comb begin
        w_pick = 7'd0;
        if (exc_req[c_RST])      w_pick[c_RST] = 1'b1;
        else if (exc_req[c_DAB]) w_pick[c_DAB] = 1'b1;
        else if (exc_req[c_FIQ]) w_pick[c_FIQ] = 1'b1;
        else if (exc_req[c_IRQ]) w_pick[c_IRQ] = 1'b1;
        else if (exc_req[c_PAB]) w_pick[c_PAB] = 1'b1;
        else if (exc_req[c_UND]) w_pick[c_UND] = 1'b1;
        else if (exc_req[c_SWI]) w_pick[c_SWI] = 1'b1;
    end

    // Target mode and vector offset of the latched source (reset is the fallback)
    always_comb begin
        w_mode    = 5'b10011;
        w_vec_off = 8'h00;
        if (r_sel[c_UND]) begin
            w_mode    = 5'b11011;
            w_vec_off = 8'h04;
        end else if (r_sel[c_SWI]) begin
            w_mode    = 5'b10011;
            w_vec_off = 8'h08;
        end else if (r_sel[c_PAB]) begin
            w_mode    = 5'b10111;
            w_vec_off = 8'h0C;
        end else if (r_sel[c_DAB]) begin
            w_mode    = 5'b10111;
            w_vec_off = 8'h10;
        end else if (r_sel[c_IRQ]) begin
            w_mode    = 5'b10010;
            w_vec_off = 8'h18;
        end else if (r_sel[c_FIQ]) begin
            w_mode    = 5'b10001;
            w_vec_off = 8'h1C;
        end
    end

    // CPSR read data is live during WR_CPSR, so mask test and new CPSR use it directly
    assign w_masked   = (r_sel[c_IRQ] & cpsr_read_value[7]) |
                        (r_sel[c_FIQ] & cpsr_read_value[6]);
    assign w_cpsr_new = {cpsr_read_value[31:8], 1'b1,
                         (r_sel[c_FIQ] | r_sel[c_RST]) ? 1'b1 : cpsr_read_value[6],
                         1'b0, w_mode};
    assign w_lr_value = r_sel[c_DAB] ? r_pc_cap : (r_pc_cap - 32'd4);
    assign w_pc_value = VEC_BASE + {24'd0, w_vec_off};

    // Entry sequencer: one state per cycle, reset returns to IDLE from anywhere
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_sel      <= 7'd0;
            r_pc_cap   <= 32'd0;
            r_cpsr_old <= 32'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (|exc_req) begin
                        r_sel   <= w_pick;
                        r_state <= c_S_RD_PC;
                    end
                end
                c_S_RD_PC:   r_state <= c_S_RD_CPSR;
                c_S_RD_CPSR: begin
                    r_pc_cap <= rf_read_value;
                    r_state  <= c_S_WR_CPSR;
                end
                c_S_WR_CPSR: begin
                    r_cpsr_old <= cpsr_read_value;
                    if (w_masked)          r_state <= c_S_IDLE;
                    else if (r_sel[c_RST]) r_state <= c_S_WR_PC;
                    else                   r_state <= c_S_WR_SPSR;
                end
                c_S_WR_SPSR: r_state <= c_S_WR_LR;
                c_S_WR_LR:   r_state <= c_S_WR_PC;
                c_S_WR_PC:   r_state <= c_S_DONE;
                c_S_DONE:    r_state <= c_S_IDLE;
                default:     r_state <= c_S_IDLE;
            endcase
        end
    end

    // Output decode: each enable is high only in its own state
    always_comb begin
        busy             = (r_state != c_S_IDLE);
        done             = 1'b0;
        exc_ack          = 7'd0;
        rf_read_en       = 1'b0;
        rf_read_reg      = 4'd0;
        rf_write_en      = 1'b0;
        rf_write_reg     = 4'd0;
        rf_write_value   = 32'd0;
        cpsr_read_en     = 1'b0;
        cpsr_write_en    = 1'b0;
        cpsr_write_value = w_cpsr_new;
        spsr_write_en    = 1'b0;
        spsr_write_value = r_cpsr_old;
        case (r_state)
            c_S_RD_PC: begin
                rf_read_en  = 1'b1;
                rf_read_reg = 4'd15;
            end
            c_S_RD_CPSR: cpsr_read_en = 1'b1;
            c_S_WR_CPSR: cpsr_write_en = ~w_masked;
            c_S_WR_SPSR: spsr_write_en = 1'b1;
            c_S_WR_LR: begin
                rf_write_en    = 1'b1;
                rf_write_reg   = 4'd14;
                rf_write_value = w_lr_value;
            end
            c_S_WR_PC: begin
                rf_write_en    = 1'b1;
                rf_write_reg   = 4'd15;
                rf_write_value = w_pc_value;
            end
            c_S_DONE: begin
                done    = 1'b1;
                exc_ack = r_sel;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/exception_entry_ctrl.md
EXCEPTION_ENTRY_CTRL -- requirements
Module: exception_entry_ctrl

Interface
REQ-001 SHALL have parameter VEC_BASE, default 32'h00000000, exception vector table base address.
REQ-002 SHALL have ports:
- clk  in  1  system clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- exc_req  in  7  level requests [0]reset [1]undef [2]swi [3]pabort [4]dabort [5]irq [6]fiq.
- exc_ack  out  7  one-hot acknowledge, one-cycle pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when entry completes.
- rf_read_en  out  1  register file read enable.
- rf_read_reg  out  4  register file read index.
- rf_read_value  in  32  read data, valid the cycle after rf_read_en.
- rf_write_en  out  1  register file write enable.
- rf_write_reg  out  4  register file write index.
- rf_write_value  out  32  register file write data.
- cpsr_read_en  out  1  CPSR read enable.
- cpsr_read_value  in  32  CPSR data, valid the cycle after cpsr_read_en.
- cpsr_write_en  out  1  CPSR write enable.
- cpsr_write_value  out  32  new CPSR.
- spsr_write_en  out  1  SPSR (current-mode bank) write enable.
- spsr_write_value  out  32  SPSR data.

Function
REQ-003 SHALL implement FSM IDLE, RD_PC, RD_CPSR, WR_CPSR, WR_SPSR, WR_LR, WR_PC, DONE; one state per cycle.
REQ-004 In IDLE, SHALL latch the highest-priority active request, priority reset > dabort > fiq > irq > pabort > undef > swi, and go to RD_PC; otherwise stay in IDLE.
REQ-005 RD_PC SHALL drive rf_read_en=1, rf_read_reg=15.
REQ-006 RD_CPSR SHALL capture rf_read_value as pc_cap and drive cpsr_read_en=1.
REQ-007 WR_CPSR SHALL capture cpsr_read_value as cpsr_old; if the selection is irq with cpsr_old[7]=1, or fiq with cpsr_old[6]=1, SHALL write nothing, pulse nothing, and return to IDLE.
REQ-008 Otherwise WR_CPSR SHALL drive cpsr_write_en=1 with cpsr_old modified: [4:0]=mode, [7]=1, [5]=0, [6]=1 for fiq/reset, else [6] unchanged.
REQ-009 Modes: reset/swi 5'b10011, undef 5'b11011, pabort/dabort 5'b10111, irq 5'b10010, fiq 5'b10001.
REQ-010 WR_SPSR SHALL drive spsr_write_en=1, spsr_write_value=cpsr_old.
REQ-011 WR_LR SHALL drive rf_write_en=1, rf_write_reg=14, value pc_cap for dabort and pc_cap-4 for all others; arithmetic is modulo 2^32.
REQ-012 WR_PC SHALL drive rf_write_en=1, rf_write_reg=15, value VEC_BASE + offset: reset 0x00, undef 0x04, swi 0x08, pabort 0x0C, dabort 0x10, irq 0x18, fiq 0x1C.
REQ-013 For reset selection, WR_CPSR SHALL go directly to WR_PC, skipping WR_SPSR and WR_LR.
REQ-014 DONE SHALL pulse done=1 and exc_ack one-hot for the serviced source, then return to IDLE.
REQ-015 Latency: done SHALL be high in the 7th cycle after the sampling IDLE edge (5th for reset).
REQ-016 Requests arriving or changing while busy SHALL be ignored; they are re-evaluated in IDLE.
REQ-017 All enables SHALL be 0 in states not listed as driving them; at most one write enable SHALL be high per cycle.

Reset
REQ-018 reset=1 at a posedge SHALL force IDLE from any state, including mid-sequence, with busy, done, exc_ack and all enables 0 from the next cycle; no partial write SHALL be completed after reset.

Verification
REQ-019 irq only, CPSR=0x000000D3 with I=0 replaced by 0x00000053, R15=0x00003008 -> CPSR write 0x000000D2, SPSR 0x00000053, R14=0x00003004, R15=0x00000018, done at cycle 7, exc_ack=7'b0100000.
REQ-020 irq with CPSR=0x000000D3 (I=1) -> no write enables, no done, FSM back in IDLE after WR_CPSR.
REQ-021 dabort and irq together, R15=0x00001010 -> dabort serviced: R14=0x00001010, R15=0x00000010, CPSR mode 10111.
REQ-022 reset request -> CPSR[7:0]=0xD3, no SPSR/R14 write, R15=VEC_BASE, done at cycle 5.
REQ-023 reset asserted during WR_SPSR -> no LR/PC write, busy=0 next cycle.
REQ-024 R15=0x00000000 with swi -> R14=0xFFFFFFFC (wrap), R15=0x00000008.
